uart_tx_arb: RTL and testbench

Packet-atomic arbiter that shares the single UART transmit engine on the ULX3S 6502 platform between two byte requesters: port A (CPU UART register path) and port B (debug/monitor path). Grants are round-robin between packets. A grant is held until the owner sends a byte marked `last`, or until the owner stays idle mid-packet for `LOCK_TMO` cycles. Sits between the requesters and the 8N1 serializer that drives `TX`.

---
 rtl/uart_tx_arb.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//   Packet-atomic round-robin arbiter sharing one 8N1 UART transmit engine
//   between port A (CPU UART register path) and port B (debug/monitor path).
//   The grant is held until the owner sends a byte marked last, or until the
//   owner leaves its valid low mid-packet for LOCK_TMO consecutive cycles.
//
// Parameters
//   LOCK_TMO    idle SEND cycles tolerated mid-packet before a forced release
//               (1..65535)
//
// Ports
//   clk, reset_n            system clock, async active-low reset
//   a_valid/a_data/a_last   port A byte request, a_ready = byte taken
//   b_valid/b_data/b_last   port B byte request, b_ready = byte taken
//   tx_start, tx_data       one-cycle start pulse and byte to the serializer
//   tx_busy                 serializer busy (rises the cycle after tx_start)
//   grant                   one-hot owner: bit0 = A, bit1 = B, 00 = none
//   timeout_evt             one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter logic [15:0] LOCK_TMO = 16'd50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  input  logic       a_last,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  input  logic       b_last,
  output logic       b_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_evt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, START = 2'd2, DRAIN = 2'd3} state_t;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  state_t      state, state_nxt;
  port_t       owner, owner_nxt;
  port_t       prio, prio_nxt;
  port_t       pick, other;
  logic [15:0] idle_cnt, idle_cnt_nxt;
  logic        last_q, last_nxt;
  logic [1:0]  grant_nxt;
  logic        tx_start_nxt;
  logic [7:0]  tx_data_nxt;
  logic        timeout_nxt;

  logic        own_valid, own_last;
  logic [7:0]  own_data;
  logic        send_open;

  // Owner-side view of the request so SEND logic is port-agnostic.
  assign own_valid = (owner == PORT_B) ? b_valid : a_valid;
  assign own_data  = (owner == PORT_B) ? b_data  : a_data;
  assign own_last  = (owner == PORT_B) ? b_last  : a_last;

  // Ready derives from registered state only plus tx_busy, so it drops the
  // moment the serializer is busy and never reaches the non-owner.
  assign send_open = (state == SEND) && !tx_busy;
  assign a_ready   = send_open && (owner == PORT_A);
  assign b_ready   = send_open && (owner == PORT_B);

  // IDLE winner: a lone requester wins outright, a tie goes to prio.
  assign pick  = (a_valid && b_valid) ? prio : (b_valid ? PORT_B : PORT_A);
  assign other = (owner == PORT_A) ? PORT_B : PORT_A;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_nxt    = state;
    owner_nxt    = owner;
    prio_nxt     = prio;
    idle_cnt_nxt = idle_cnt;
    last_nxt     = last_q;
    grant_nxt    = grant;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    timeout_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (a_valid || b_valid) begin
          owner_nxt    = pick;
          grant_nxt    = (pick == PORT_B) ? 2'b10 : 2'b01;
          idle_cnt_nxt = '0;
          state_nxt    = SEND;
        end
      end

      SEND: begin
        if (own_valid && !tx_busy) begin
          tx_data_nxt  = own_data;
          tx_start_nxt = 1'b1;
          last_nxt     = own_last;
          idle_cnt_nxt = '0;
          state_nxt    = START;
        end else if (!own_valid) begin
          if (idle_cnt == LOCK_TMO - 16'd1) begin
            // Owner stalled mid-packet: drop the lock and hand over priority.
            timeout_nxt  = 1'b1;
            prio_nxt     = other;
            grant_nxt    = 2'b00;
            idle_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else if (idle_cnt != 16'hFFFF) begin
            idle_cnt_nxt = idle_cnt + 16'd1;
          end
        end
      end

      START: begin
        state_nxt = DRAIN;
      end

      DRAIN: begin
        if (!tx_busy) begin
          if (last_q) begin
            prio_nxt  = other;
            grant_nxt = 2'b00;
            state_nxt = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every flop here is a control register, not storage, so all of them
  // take the async reset; a reset mid-byte just stops further starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= PORT_A;
      prio        <= PORT_A;
      idle_cnt    <= '0;
      last_q      <= 1'b0;
      grant       <= 2'b00;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      timeout_evt <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state       <= state_nxt;
      owner       <= owner_nxt;
      prio        <= prio_nxt;
      idle_cnt    <= idle_cnt_nxt;
      last_q      <= last_nxt;
      grant       <= grant_nxt;
      tx_start    <= tx_start_nxt;
      tx_data     <= tx_data_nxt;
      timeout_evt <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//   Self-checking bench for uart_tx_arb (LOCK_TMO = 8). Two queue-driven
//   requesters feed the arbiter; a serializer model holds tx_busy for 10
//   cycles after each start. Expected bytes are queued in the order the
//   arbitration rules dictate and compared as tx_start pulses appear.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_valid, a_last, a_ready;
  logic       b_valid, b_last, b_ready;
  logic [7:0] a_data, b_data, tx_data;
  logic       tx_start, tx_busy, timeout_evt;
  logic [1:0] grant;
  logic       force_busy;

  logic [8:0] a_q[$];
  logic [8:0] b_q[$];
  logic [7:0] exp_q[$];
  bit         en_a, en_b;
  bit         fire_a, fire_b;

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   n_start    = 0;
  int   n_evt      = 0;
  int   ready_viol = 0;
  int   ser_cnt    = 0;
  logic prev_start = 1'b0;

  uart_tx_arb #(.LOCK_TMO(16'd8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .a_valid     (a_valid),
    .a_data      (a_data),
    .a_last      (a_last),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_data      (b_data),
    .b_last      (b_last),
    .b_ready     (b_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant       (grant),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  // Serializer: busy from the cycle after tx_start for 10 cycles.
  always @(posedge clk) begin
    if (tx_start) ser_cnt <= 10;
    else if (ser_cnt > 0) ser_cnt <= ser_cnt - 1;
  end
  assign tx_busy = (ser_cnt != 0) || force_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic update_ports();
    logic [8:0] h;
    h       = (a_q.size() > 0) ? a_q[0] : 9'h000;
    a_valid = en_a && (a_q.size() > 0);
    a_data  = h[7:0];
    a_last  = h[8];
    h       = (b_q.size() > 0) ? b_q[0] : 9'h000;
    b_valid = en_b && (b_q.size() > 0);
    b_data  = h[7:0];
    b_last  = h[8];
  endtask

  task automatic push_a(input logic [7:0] d, input logic l);
    a_q.push_back({l, d});
  endtask

  task automatic push_b(input logic [7:0] d, input logic l);
    b_q.push_back({l, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Requesters: handshake decided mid-cycle, queue advanced after the edge.
  always begin
    @(negedge clk);
    fire_a = a_valid && a_ready;
    fire_b = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (fire_a) void'(a_q.pop_front());
    if (fire_b) void'(b_q.pop_front());
    update_ports();
  end

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    logic [7:0] e;
    if (tx_start) begin
      n_start++;
      check("start_pulse_width", prev_start, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_start", tx_data, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", tx_data, e);
      end
    end
    prev_start = tx_start;
    if (timeout_evt) n_evt++;
    if ((grant == 2'b01 && b_ready) || (grant == 2'b10 && a_ready)) ready_viol++;
  end

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && grant == 2'b00 && !tx_busy) done = 1'b1;
    end
    check(tag, done, 1'b1);
    tick();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    en_a       = 1'b0;
    en_b       = 1'b0;
    force_busy = 1'b0;
    a_q.delete();
    b_q.delete();
    update_ports();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int  s0, idle, rc;
    bit  seen;

    reset_n    = 1'b0;
    force_busy = 1'b0;
    en_a       = 1'b0;
    en_b       = 1'b0;
    update_ports();

    // Reset with both requesters asserting valid.
    push_a(8'hA5, 1'b1);
    push_b(8'h5A, 1'b1);
    en_a = 1'b1;
    en_b = 1'b1;
    update_ports();
    repeat (3) tick();
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    tick();
    b_q.delete();
    en_b = 1'b0;
    update_ports();
    exp_q.push_back(8'hA5);
    reset_n = 1'b1;
    @(negedge clk);
    check("grant_before_edge", grant, 2'b00);
    @(negedge clk);
    check("first_grant", grant, 2'b01);
    wait_idle("rst_pkt_done", 100);

    // Single 3-byte packet from A, then prio must favour B.
    do_reset();
    s0 = n_start;
    push_a(8'h48, 1'b0); push_a(8'h69, 1'b0); push_a(8'h0A, 1'b1);
    exp_q.push_back(8'h48); exp_q.push_back(8'h69); exp_q.push_back(8'h0A);
    en_a = 1'b1;
    update_ports();
    wait_idle("pktA_done", 200);
    check("pktA_starts", n_start - s0, 3);
    push_a(8'h31, 1'b1);
    push_b(8'h32, 1'b1);
    exp_q.push_back(8'h32); exp_q.push_back(8'h31);
    en_b = 1'b1;
    update_ports();
    wait_idle("prio_b_done", 200);

    // Contention: packets alternate, non-owner never ready.
    do_reset();
    ready_viol = 0;
    push_a(8'h11, 1'b0); push_a(8'h12, 1'b1); push_a(8'h11, 1'b0); push_a(8'h12, 1'b1);
    push_b(8'h21, 1'b1); push_b(8'h21, 1'b1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h21);
    exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h21);
    en_a = 1'b1;
    en_b = 1'b1;
    update_ports();
    wait_idle("contention_done", 400);
    check("nonowner_ready", ready_viol, 0);

    // Timeout: A stalls mid-packet while B waits.
    do_reset();
    s0 = n_evt;
    push_a(8'h55, 1'b0);
    push_b(8'h77, 1'b1);
    exp_q.push_back(8'h55); exp_q.push_back(8'h77);
    en_a = 1'b1;
    en_b = 1'b1;
    update_ports();
    idle = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (timeout_evt) seen = 1'b1;
      else if (a_ready && !a_valid) idle++;
    end
    check("timeout_seen", seen, 1'b1);
    check("timeout_idle_cycles", idle, 8);
    check("timeout_grant_clear", grant, 2'b00);
    @(negedge clk);
    check("timeout_grant_b", grant, 2'b10);
    check("timeout_evt_pulse", timeout_evt, 1'b0);
    wait_idle("timeout_done", 200);
    check("timeout_count", n_evt - s0, 1);

    // Reset during DRAIN of a non-last byte.
    do_reset();
    push_a(8'h61, 1'b0);
    push_a(8'h62, 1'b1);
    exp_q.push_back(8'h61);
    en_a = 1'b1;
    update_ports();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) seen = 1'b1;
    end
    check("midrst_first_start", seen, 1'b1);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_grant", grant, 2'b00);
    check("midrst_tx_start", tx_start, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_a_ready", a_ready, 1'b0);
    tick();
    en_a = 1'b0;
    update_ports();
    reset_n = 1'b1;
    s0 = n_start;
    repeat (30) tick();
    check("midrst_no_start", n_start - s0, 0);
    check("midrst_idle_grant", grant, 2'b00);
    exp_q.push_back(8'h62);
    en_a = 1'b1;
    update_ports();
    wait_idle("midrst_resume_done", 200);

    // Busy gating: tx_busy held high while A owns SEND.
    do_reset();
    force_busy = 1'b1;
    push_a(8'h99, 1'b1);
    en_a = 1'b1;
    update_ports();
    s0 = n_start;
    @(negedge clk);
    @(negedge clk);
    check("busy_grant", grant, 2'b01);
    rc = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_ready) rc++;
    end
    check("busy_ready_low", rc, 0);
    check("busy_no_start", n_start - s0, 0);
    tick();
    exp_q.push_back(8'h99);
    force_busy = 1'b0;
    #1;
    check("busy_release_ready", a_ready, 1'b1);
    wait_idle("busy_done", 100);

    check("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
